// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the IO bus master: IO address map, status bit positions, FSM states.
// The LOG_WR state only exists when IOM_LOG_EN is defined.
package io_map_pkg;

  localparam logic [31:0] IO_STATUS = 32'h0000_0080;
  localparam logic [31:0] IO_LED    = 32'h0000_0084;
  localparam logic [31:0] IO_SWITCH = 32'h0000_0088;

  localparam int STAT_SW_RDY  = 1;
  localparam int STAT_LED_RDY = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POLL_SW,
    ST_WAIT_SW,
    ST_READ_SW,
    ST_CALC,
    ST_POLL_LED,
    ST_WAIT_LED,
    ST_WRITE_LED
`ifdef IOM_LOG_EN
    , ST_LOG_WR
`endif
  } state_t;

  // 9-bit byte sum, zero-extended to the 12-bit LED width; no saturation.
  function automatic logic [11:0] switch_sum(input logic [15:0] sw);
    logic [8:0] s;
    s = {1'b0, sw[15:8]} + {1'b0, sw[7:0]};
    return {3'b000, s};
  endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Data-memory/IO decode bus: the master drives address/strobe/data, the slave returns read data
// combinationally in the same cycle as the address.
interface io_bus_master_if;

  logic [31:0] data_addr;
  logic        write_EN;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output data_addr,
    output write_EN,
    output write_data,
    input  read_data
  );

  modport slave (
    input  data_addr,
    input  write_EN,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/io_bus_master_poll_gap_timer.sv
// Re-poll back-off timer: load starts a POLL_GAP-cycle window, expire is high in its last cycle.
module poll_gap_timer #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned CW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [CW-1:0] r_count;
  logic          r_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_count  <= CW'(POLL_GAP - 1);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign expire = r_active && (r_count == '0);

endmodule

// File: rtl/io_bus_master.sv
// Hardware board-IO loop: poll switch-ready, read switches, add the two bytes, poll LED-ready, write LED.
// Defining IOM_LOG_EN adds a LOG_WR state that appends every LED value to a circular log in data memory.
module io_bus_master
  import io_map_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 4
`ifdef IOM_LOG_EN
  , parameter logic [31:0] LOG_BASE  = 32'h0000_0040
  , parameter int unsigned LOG_DEPTH = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  io_bus_master_if.master    bus,
  output logic               busy,
  output logic [15:0]        done_count,
  output logic [11:0]        last_result
);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_data_addr;
  logic        r_write_en;
  logic [31:0] r_write_data;
  logic        r_busy;
  logic [15:0] r_done_count;
  logic [11:0] r_last_result;
  logic [15:0] r_switch;
  logic [11:0] r_sum;

  logic [31:0] w_addr_next;
  logic        w_we_next;
  logic [31:0] w_wdata_next;
  logic        w_gap_load;
  logic        w_gap_expire;
  logic [15:0] w_unused_rd_hi;

  assign w_unused_rd_hi = bus.read_data[31:16];

`ifdef IOM_LOG_EN
  localparam int unsigned IW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [IW-1:0] r_log_idx;
  logic [31:0]   w_log_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_log_idx <= '0;
    end else if (r_state == ST_LOG_WR) begin
      r_log_idx <= (r_log_idx == IW'(LOG_DEPTH - 1)) ? '0 : r_log_idx + 1'b1;
    end
  end

  assign w_log_addr = LOG_BASE + 32'({r_log_idx, 2'b00});
`endif

  poll_gap_timer #(
    .POLL_GAP (POLL_GAP)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_gap_load),
    .expire (w_gap_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Status decisions use read_data of the poll cycle itself, so the branch happens on leaving it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_POLL_SW;
      ST_POLL_SW:   w_state_next = bus.read_data[STAT_SW_RDY] ? ST_READ_SW : ST_WAIT_SW;
      ST_WAIT_SW:   if (w_gap_expire) w_state_next = ST_POLL_SW;
      ST_READ_SW:   w_state_next = ST_CALC;
      ST_CALC:      w_state_next = ST_POLL_LED;
      ST_POLL_LED:  w_state_next = bus.read_data[STAT_LED_RDY] ? ST_WRITE_LED : ST_WAIT_LED;
      ST_WAIT_LED:  if (w_gap_expire) w_state_next = ST_POLL_LED;
`ifdef IOM_LOG_EN
      ST_WRITE_LED: w_state_next = ST_LOG_WR;
      ST_LOG_WR:    w_state_next = start ? ST_POLL_SW : ST_IDLE;
`else
      ST_WRITE_LED: w_state_next = start ? ST_POLL_SW : ST_IDLE;
`endif
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so they line up with that state.
  always_comb begin
    w_addr_next  = '0;
    w_we_next    = 1'b0;
    w_wdata_next = '0;
    w_gap_load   = ((w_state_next == ST_WAIT_SW)  && (r_state != ST_WAIT_SW)) ||
                   ((w_state_next == ST_WAIT_LED) && (r_state != ST_WAIT_LED));
    case (w_state_next)
      ST_POLL_SW,
      ST_POLL_LED:  w_addr_next = IO_STATUS;
      ST_READ_SW:   w_addr_next = IO_SWITCH;
      ST_WRITE_LED: begin
        w_addr_next  = IO_LED;
        w_we_next    = 1'b1;
        w_wdata_next = {20'b0, r_sum};
      end
`ifdef IOM_LOG_EN
      ST_LOG_WR: begin
        w_addr_next  = w_log_addr;
        w_we_next    = 1'b1;
        w_wdata_next = {20'b0, r_sum};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_addr   <= '0;
      r_write_en    <= 1'b0;
      r_write_data  <= '0;
      r_busy        <= 1'b0;
      r_done_count  <= '0;
      r_last_result <= '0;
      r_switch      <= '0;
      r_sum         <= '0;
    end else begin
      r_data_addr  <= w_addr_next;
      r_write_en   <= w_we_next;
      r_write_data <= w_wdata_next;
      r_busy       <= (w_state_next != ST_IDLE);
      if (r_state == ST_READ_SW) begin
        r_switch <= bus.read_data[15:0];
      end
      if (r_state == ST_CALC) begin
        r_sum <= switch_sum(r_switch);
      end
      if (r_state == ST_WRITE_LED) begin
        r_last_result <= r_sum;
        r_done_count  <= r_done_count + 16'd1;
      end
    end
  end

  assign bus.data_addr  = r_data_addr;
  assign bus.write_EN   = r_write_en;
  assign bus.write_data = r_write_data;
  assign busy           = r_busy;
  assign done_count     = r_done_count;
  assign last_result    = r_last_result;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: IO-port stand-in, timeline model of expected bus accesses, directed scenarios.
`timescale 1ns/1ps
module tb_io_bus_master;

  localparam int          GAP    = 4;
  localparam logic [31:0] LBASE  = 32'h0000_0040;
  localparam int          LDEPTH = 8;

  localparam int K_STAT_SW  = 0;
  localparam int K_SW       = 1;
  localparam int K_STAT_LED = 2;
  localparam int K_LED      = 3;
  localparam int K_LOG      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  status = 2'b00;
  logic [15:0] switch_val = 16'h0000;
  logic        busy;
  logic [15:0] done_count;
  logic [11:0] last_result;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // model state
  bit          m_busy = 0;
  bit          pend = 0;
  int          pend_t = 0;
  logic [31:0] pend_addr = '0;
  bit          pend_we = 0;
  logic [31:0] pend_wd = '0;
  int          pend_kind = 0;
  logic [11:0] m_sum = '0;
  logic [11:0] m_last = '0;
  logic [15:0] m_done = '0;
  int          m_idx = 0;

  // observations for the literal checks
  logic [31:0] obs_led_data = '0;
  int          n_led_wr = 0;
  int          n88 = 0;
  logic [31:0] log_q[$];

  io_bus_master_if bus ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.read_data = (bus.data_addr == 32'h80) ? {30'b0, status} :
                         (bus.data_addr == 32'h88) ? {16'b0, switch_val} : 32'h0;

  io_bus_master #(
    .POLL_GAP (GAP)
`ifdef IOM_LOG_EN
    , .LOG_BASE  (LBASE)
    , .LOG_DEPTH (LDEPTH)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done_count  (done_count),
    .last_result (last_result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: got timeout, expected event within bound (t=%0t)", nm, $time);
  endtask

  task automatic set_pend(input int t, input logic [31:0] a, input bit we,
                          input logic [31:0] wd, input int k);
    pend      = 1;
    pend_t    = t;
    pend_addr = a;
    pend_we   = we;
    pend_wd   = wd;
    pend_kind = k;
  endtask

  // Compare process: every cycle the expected bus access (or silence) is checked.
  initial begin : compare
    logic        hit, e_we, loop_end;
    logic [31:0] e_addr, e_wd, rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; pend = 0; m_done = '0; m_last = '0; m_idx = 0;
      end
      hit    = pend && (pend_t == cyc);
      e_addr = hit ? pend_addr : 32'h0;
      e_we   = hit && pend_we;
      e_wd   = hit ? pend_wd : 32'h0;
      chk("data_addr",   bus.data_addr,  e_addr);
      chk("write_EN",    32'(bus.write_EN), 32'(e_we));
      chk("write_data",  bus.write_data, e_wd);
      chk("busy",        32'(busy),      32'(m_busy));
      chk("done_count",  32'(done_count), 32'(m_done));
      chk("last_result", 32'(last_result), 32'(m_last));
      if (bus.write_EN) begin
        $display("txn cycle=%0d write addr=0x%0h data=0x%0h", cyc, bus.data_addr, bus.write_data);
        if (bus.data_addr == 32'h84) begin
          obs_led_data = bus.write_data;
          n_led_wr++;
        end else begin
          log_q.push_back(bus.data_addr);
        end
      end
      if (bus.data_addr == 32'h88) n88++;
      loop_end = 0;
      if (rst) begin
        rd = (e_addr == 32'h80) ? {30'b0, status} :
             (e_addr == 32'h88) ? {16'b0, switch_val} : 32'h0;
        if (!m_busy) begin
          if (start) begin
            set_pend(cyc + 1, 32'h80, 0, 32'h0, K_STAT_SW);
            m_busy = 1;
          end
        end else if (hit) begin
          case (pend_kind)
            K_STAT_SW:
              if (rd[1]) set_pend(cyc + 1, 32'h88, 0, 32'h0, K_SW);
              else       set_pend(cyc + 1 + GAP, 32'h80, 0, 32'h0, K_STAT_SW);
            K_SW: begin
              m_sum = 12'(rd[15:8]) + 12'(rd[7:0]);
              set_pend(cyc + 2, 32'h80, 0, 32'h0, K_STAT_LED);
            end
            K_STAT_LED:
              if (rd[0]) set_pend(cyc + 1, 32'h84, 1, {20'b0, m_sum}, K_LED);
              else       set_pend(cyc + 1 + GAP, 32'h80, 0, 32'h0, K_STAT_LED);
            K_LED: begin
              m_done = m_done + 16'd1;
              m_last = m_sum;
`ifdef IOM_LOG_EN
              set_pend(cyc + 1, LBASE + 32'(4 * m_idx), 1, {20'b0, m_sum}, K_LOG);
`else
              loop_end = 1;
`endif
            end
            K_LOG: begin
              m_idx    = (m_idx + 1) % LDEPTH;
              loop_end = 1;
            end
            default: ;
          endcase
          if (loop_end) begin
            if (start) set_pend(cyc + 1, 32'h80, 0, 32'h0, K_STAT_SW);
            else begin
              pend   = 0;
              m_busy = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_addr(input logic [31:0] a, input string nm, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.data_addr == a) return;
    end
    timeout_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    timeout_fail(nm);
  endtask

  task automatic wait_we(input string nm);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (bus.write_EN) return;
    end
    timeout_fail(nm);
  endtask

  initial begin : stimulus
    int n;
    int t_poll[3];
    int np, n88_loc, k, base;

    // reset held with start=1: bus silent
    start = 1'b1; status = 2'b11; switch_val = 16'h1234;
    repeat (4) @(posedge clk);
    #3;
    chk("rst_data_addr", bus.data_addr, 32'h0);
    chk("rst_write_EN",  32'(bus.write_EN), 32'h0);
    rst = 1'b1;

    // one loop, status=3, switch=0x1234
    wait_addr(32'h80, "first_poll", n);
    chk("first_poll_latency", 32'(n), 32'd1);
    start = 1'b0;
    wait_idle("idle_after_1234");
    chk("lit_done_1",  32'(done_count), 32'd1);
    chk("lit_last_1",  32'(last_result), 32'h046);
    chk("lit_ledw_1",  obs_led_data, 32'h046);
    chk("lit_nwr_1",   32'(n_led_wr), 32'd1);
    chk("lit_n88_1",   32'(n88), 32'd1);

    // overflow case
    switch_val = 16'hFFFF;
    start = 1'b1;
    wait_addr(32'h80, "poll_ffff", n);
    start = 1'b0;
    wait_idle("idle_after_ffff");
    chk("lit_last_ffff", 32'(last_result), 32'h1FE);
    chk("lit_ledw_ffff", obs_led_data, 32'h0000_01FE);
    chk("lit_done_2",    32'(done_count), 32'd2);

    // switch-ready low for three polls
    status = 2'b01; switch_val = 16'h0102;
    start = 1'b1;
    np = 0; n88_loc = 0; k = 0;
    for (int i = 0; i < 100 && np < 3; i++) begin
      @(posedge clk); #1;
      k++;
      if (bus.data_addr == 32'h88) n88_loc++;
      if (bus.data_addr == 32'h80) begin
        t_poll[np] = k;
        np++;
        start = 1'b0;
      end
    end
    if (np < 3) timeout_fail("three_polls");
    @(posedge clk); #1;
    if (bus.data_addr == 32'h88) n88_loc++;
    chk("lit_poll_gap_a", 32'(t_poll[1] - t_poll[0]), 32'd5);
    chk("lit_poll_gap_b", 32'(t_poll[2] - t_poll[1]), 32'd5);
    chk("lit_no_sw_read", 32'(n88_loc), 32'd0);
    status = 2'b11;
    wait_idle("idle_after_polls");
    chk("lit_last_0102", 32'(last_result), 32'h003);
    chk("lit_done_3",    32'(done_count), 32'd3);

    // start dropped while waiting for LED-ready
    status = 2'b10; switch_val = 16'h0A0B;
    start = 1'b1;
    wait_addr(32'h88, "sw_read_0a0b", n);
    wait_addr(32'h80, "led_poll_0a0b", n);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    status = 2'b11;
    wait_idle("idle_after_wait_led");
    chk("lit_done_4",     32'(done_count), 32'd4);
    chk("lit_last_0a0b",  32'(last_result), 32'h015);
    chk("lit_nwr_4",      32'(n_led_wr), 32'd4);
    chk("lit_idle_addr",  bus.data_addr, 32'h0);

    // reset during the LED write
    switch_val = 16'h1111;
    start = 1'b1;
    wait_we("we_before_rst");
    #1;
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("lit_rst_we_async",   32'(bus.write_EN), 32'h0);
    chk("lit_rst_addr_async", bus.data_addr, 32'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_done_after_rst", 32'(done_count), 32'd0);
    chk("lit_last_after_rst", 32'(last_result), 32'h0);

`ifdef IOM_LOG_EN
    // nine loops walk the circular log once and wrap
    switch_val = 16'h0001;
    base = log_q.size();
    start = 1'b1;
    for (int i = 0; i < 2000 && log_q.size() < base + 9; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (log_q.size() < base + 9) timeout_fail("nine_log_writes");
    wait_idle("idle_after_log");
    for (int i = 0; i < 9; i++) begin
      if (base + i < log_q.size())
        chk("lit_log_addr", log_q[base + i], 32'h40 + 32'(4 * (i % 8)));
    end
`else
    base = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
